data_mem_responder: RTL and testbench

- Responder end of the CPU data-memory port. Serves the CPU's combinational read address and its write address, data and enable, and returns the read data in the same cycle.
- CPU stores are posted into a small write queue that drains into a slow-write word array, one entry every WRITE_CYCLES cycles.
- A host load/dump port shares the queue and the array.
- o_cpu_stall is the CPU-side backpressure and is gated into the CPU's clk_enable at top level.

---
 rtl/data_mem_responder_pkg.sv | 9 +
 rtl/data_mem_responder_write_queue.sv | 72 +++++++
 rtl/data_mem_responder.sv | 119 +++++++++++
 tb/tb_data_mem_responder.sv | 251 +++++++++++++++++++++++++
 4 files changed

// File: rtl/data_mem_responder_pkg.sv
// data_mem_responder_pkg: shared constants and drain-state encoding for the data-memory responder
package data_mem_responder_pkg;
    localparam int DMEM_WQ_DEPTH = 4;
    localparam int DMEM_WRITE_CYCLES = 2;
    typedef enum logic {
        DMEM_DRAIN_IDLE = 1'b0,
        DMEM_DRAIN_BUSY = 1'b1
    } drain_state_t;
endpackage

// File: rtl/data_mem_responder_write_queue.sv
// data_mem_responder_write_queue: posted-write FIFO with youngest-match forwarding on two lookup ports
module data_mem_responder_write_queue
    import data_mem_responder_pkg::*;
#(
    parameter int IDX_WIDTH = 6,
    parameter int DATA_WIDTH = 32,
    parameter int DEPTH = DMEM_WQ_DEPTH
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    clk_enable,
    input  logic                    enq,
    input  logic [IDX_WIDTH-1:0]    enq_idx,
    input  logic [DATA_WIDTH-1:0]   enq_data,
    input  logic                    deq,
    output logic [IDX_WIDTH-1:0]    head_idx,
    output logic [DATA_WIDTH-1:0]   head_data,
    output logic [$clog2(DEPTH):0]  count,
    output logic                    full,
    output logic                    empty,
    input  logic [IDX_WIDTH-1:0]    cpu_idx,
    output logic                    cpu_hit,
    output logic [DATA_WIDTH-1:0]   cpu_data,
    input  logic [IDX_WIDTH-1:0]    host_idx,
    output logic                    host_hit,
    output logic [DATA_WIDTH-1:0]   host_data
);
    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;
    logic [IDX_WIDTH-1:0] idx_q [DEPTH];
    logic [DATA_WIDTH-1:0] data_q [DEPTH];
    logic [PW-1:0] head, tail;

    // Walk entries oldest to youngest so the last match found is the youngest
    function automatic logic [DATA_WIDTH:0] lookup(input logic [IDX_WIDTH-1:0] idx);
        logic [PW-1:0] s;
        lookup = '0;
        for (int k = 0; k < DEPTH; k++) begin
            s = head + PW'(k);
            if (CW'(k) < count && idx_q[s] == idx) lookup = {1'b1, data_q[s]};
        end
    endfunction

    always_comb begin
        {cpu_hit, cpu_data} = lookup(cpu_idx);
        {host_hit, host_data} = lookup(host_idx);
    end

    assign full = count == CW'(DEPTH);
    assign empty = count == '0;
    assign head_idx = idx_q[head];
    assign head_data = data_q[head];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            head <= '0;
            tail <= '0;
            count <= '0;
        end else if (clk_enable) begin
            if (enq) tail <= tail + 1'b1;
            if (deq) head <= head + 1'b1;
            count <= count + CW'(enq) - CW'(deq);
        end
    end

    always_ff @(posedge clk) begin
        if (clk_enable && enq) begin
            idx_q[tail] <= enq_idx;
            data_q[tail] <= enq_data;
        end
    end
endmodule

// File: rtl/data_mem_responder.sv
// data_mem_responder: CPU data-memory responder with a posted write queue draining into a slow-write
// word array, plus a host load/dump port sharing the queue and array.
module data_mem_responder
    import data_mem_responder_pkg::*;
#(
    parameter int ADDR_WIDTH = 8,
    parameter int DATA_WIDTH = 32,
    parameter int DEPTH_WORDS = 64,
    parameter int WQ_DEPTH = DMEM_WQ_DEPTH,
    parameter int WRITE_CYCLES = DMEM_WRITE_CYCLES
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  clk_enable,
    input  logic [ADDR_WIDTH-1:0] i_mem_read_address,
    input  logic [ADDR_WIDTH-1:0] i_mem_write_address,
    input  logic [DATA_WIDTH-1:0] i_mem_write_data,
    input  logic                  i_mem_write_enable,
    output logic [DATA_WIDTH-1:0] o_mem_read_data,
    output logic                  o_cpu_stall,
    input  logic                  i_host_req_valid,
    input  logic                  i_host_req_write,
    input  logic [ADDR_WIDTH-1:0] i_host_addr,
    input  logic [DATA_WIDTH-1:0] i_host_wdata,
    output logic                  o_host_req_ready,
    output logic [DATA_WIDTH-1:0] o_host_rdata,
    output logic                  o_host_rdata_valid
);
    localparam int IW = ADDR_WIDTH - 2;
    localparam int CW = $clog2(WQ_DEPTH) + 1;
    localparam int WW = $clog2(WRITE_CYCLES + 1);
    logic [DATA_WIDTH-1:0] mem [DEPTH_WORDS];
    drain_state_t state, state_next;
    logic [WW-1:0] wcnt, wcnt_next;
    logic cpu_enq, host_enq, host_rd, enq, deq, full, empty, cpu_hit, host_hit, unused;
    logic [IW-1:0] cpu_idx, host_idx, head_idx;
    logic [DATA_WIDTH-1:0] head_data, cpu_fwd, host_fwd, host_word;
    logic [CW-1:0] count;

    assign cpu_idx = i_mem_read_address[ADDR_WIDTH-1:2];
    assign host_idx = i_host_addr[ADDR_WIDTH-1:2];
    assign unused = ^{i_mem_read_address[1:0], i_mem_write_address[1:0], i_host_addr[1:0]};
    assign o_cpu_stall = full;
    assign cpu_enq = i_mem_write_enable & ~full;
    // CPU stores win the single enqueue slot; host reads never wait
    assign o_host_req_ready = i_host_req_write ? ~full & ~cpu_enq : 1'b1;
    assign host_enq = i_host_req_valid & i_host_req_write & o_host_req_ready;
    assign host_rd = i_host_req_valid & ~i_host_req_write;
    assign enq = cpu_enq | host_enq;
    assign o_mem_read_data = cpu_hit ? cpu_fwd : mem[cpu_idx];
    assign host_word = host_hit ? host_fwd : mem[host_idx];

    data_mem_responder_write_queue #(
        .IDX_WIDTH(IW),
        .DATA_WIDTH(DATA_WIDTH),
        .DEPTH(WQ_DEPTH)
    ) u_wq (
        .clk(clk),
        .rst_n(rst_n),
        .clk_enable(clk_enable),
        .enq(enq),
        .enq_idx(cpu_enq ? i_mem_write_address[ADDR_WIDTH-1:2] : host_idx),
        .enq_data(cpu_enq ? i_mem_write_data : i_host_wdata),
        .deq(deq),
        .head_idx(head_idx),
        .head_data(head_data),
        .count(count),
        .full(full),
        .empty(empty),
        .cpu_idx(cpu_idx),
        .cpu_hit(cpu_hit),
        .cpu_data(cpu_fwd),
        .host_idx(host_idx),
        .host_hit(host_hit),
        .host_data(host_fwd)
    );

    always_ff @(posedge clk) begin
        if (clk_enable && deq) mem[head_idx] <= head_data;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= DMEM_DRAIN_IDLE;
            wcnt <= '0;
        end else if (clk_enable) begin
            state <= state_next;
            wcnt <= wcnt_next;
        end
    end

    // After a pop, stay busy if anything remains, including a same-cycle enqueue
    always_comb begin
        state_next = state;
        wcnt_next = wcnt;
        if (state == DMEM_DRAIN_IDLE) begin
            if (!empty) begin
                state_next = DMEM_DRAIN_BUSY;
                wcnt_next = WW'(WRITE_CYCLES - 1);
            end
        end else if (wcnt != '0) wcnt_next = wcnt - 1'b1;
        else if (count > CW'(1) || enq) wcnt_next = WW'(WRITE_CYCLES - 1);
        else state_next = DMEM_DRAIN_IDLE;
    end

    always_comb begin
        deq = state == DMEM_DRAIN_BUSY && wcnt == '0;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            o_host_rdata_valid <= 1'b0;
            o_host_rdata <= '0;
        end else if (clk_enable) begin
            o_host_rdata_valid <= host_rd;
            if (host_rd) o_host_rdata <= host_word;
        end
    end
endmodule

// File: tb/tb_data_mem_responder.sv
// tb_data_mem_responder: randomized scoreboard bench; the model is a word array of last-written values
// plus a snapshot of what has settled into the array, restored on reset.
module tb_data_mem_responder;
    logic clk = 1'b0, rst_n = 1'b0, clk_enable = 1'b1;
    logic [7:0] i_mem_read_address = '0, i_mem_write_address = '0, i_host_addr = '0;
    logic [31:0] i_mem_write_data = '0, i_host_wdata = '0;
    logic i_mem_write_enable = 1'b0, i_host_req_valid = 1'b0, i_host_req_write = 1'b0;
    logic [31:0] o_mem_read_data, o_host_rdata;
    logic o_cpu_stall, o_host_req_ready, o_host_rdata_valid;
    int checks = 0, failures = 0;
    logic [31:0] logical [64];
    logic [31:0] committed [64];
    logic [31:0] exp_q [$];

    data_mem_responder dut (
        .clk(clk),
        .rst_n(rst_n),
        .clk_enable(clk_enable),
        .i_mem_read_address(i_mem_read_address),
        .i_mem_write_address(i_mem_write_address),
        .i_mem_write_data(i_mem_write_data),
        .i_mem_write_enable(i_mem_write_enable),
        .o_mem_read_data(o_mem_read_data),
        .o_cpu_stall(o_cpu_stall),
        .i_host_req_valid(i_host_req_valid),
        .i_host_req_write(i_host_req_write),
        .i_host_addr(i_host_addr),
        .i_host_wdata(i_host_wdata),
        .o_host_req_ready(o_host_req_ready),
        .o_host_rdata(o_host_rdata),
        .o_host_rdata_valid(o_host_rdata_valid)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%h expected=%h", name, got, exp);
        end
    endtask

    task automatic fail(input string name);
        checks++;
        failures++;
        $display("FAIL %s", name);
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Host read responses are compared here, independent of the stimulus thread
    always @(negedge clk) begin
        if (rst_n && o_host_rdata_valid) begin
            if (exp_q.size() == 0) fail("host_rdata_unexpected");
            else check("host_rdata", o_host_rdata, exp_q.pop_front());
        end
    end

    task automatic cpu_store(input logic [7:0] a, input logic [31:0] d, output int waits);
        waits = 0;
        i_mem_write_address = a;
        i_mem_write_data = d;
        i_mem_write_enable = 1'b1;
        @(negedge clk);
        while (o_cpu_stall && waits < 50) begin
            @(negedge clk);
            waits++;
        end
        if (waits >= 50) fail("cpu_store_stall_timeout");
        step();
        i_mem_write_enable = 1'b0;
        logical[a[7:2]] = d;
    endtask

    task automatic host_write(input logic [7:0] a, input logic [31:0] d);
        int n = 0;
        i_host_req_valid = 1'b1;
        i_host_req_write = 1'b1;
        i_host_addr = a;
        i_host_wdata = d;
        @(negedge clk);
        while (!o_host_req_ready && n < 50) begin
            @(negedge clk);
            n++;
        end
        if (n >= 50) fail("host_write_ready_timeout");
        step();
        i_host_req_valid = 1'b0;
        logical[a[7:2]] = d;
    endtask

    task automatic host_read(input logic [7:0] a);
        i_host_req_valid = 1'b1;
        i_host_req_write = 1'b0;
        i_host_addr = a;
        @(negedge clk);
        check("host_read_ready", {31'b0, o_host_req_ready}, 1);
        exp_q.push_back(logical[a[7:2]]);
        step();
        i_host_req_valid = 1'b0;
    endtask

    task automatic cpu_read(input logic [7:0] a, input string name);
        i_mem_read_address = a;
        @(negedge clk);
        check(name, o_mem_read_data, logical[a[7:2]]);
        step();
    endtask

    task automatic drain();
        repeat (24) step();
        for (int i = 0; i < 64; i++) committed[i] = logical[i];
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        #1;
        check("rst_stall", {31'b0, o_cpu_stall}, 0);
        check("rst_rdata_valid", {31'b0, o_host_rdata_valid}, 0);
        check("rst_rdata", o_host_rdata, 0);
        step();
        step();
        rst_n = 1'b1;
        for (int i = 0; i < 64; i++) logical[i] = committed[i];
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog_timeout");
        $fatal(1, "watchdog");
    end

    initial begin
        int w [6];
        int w0, op;
        logic [7:0] a;
        logic [31:0] d;
        repeat (3) @(posedge clk);
        #1;
        check("init_stall", {31'b0, o_cpu_stall}, 0);
        check("init_rdata_valid", {31'b0, o_host_rdata_valid}, 0);
        check("init_rdata", o_host_rdata, 0);
        rst_n = 1'b1;
        for (int i = 0; i < 64; i++) host_write(8'(i * 4 + $urandom_range(0, 3)), $urandom);
        drain();
        // forwarding: a store is invisible in its own cycle, visible from the next
        i_mem_read_address = 8'h10;
        i_mem_write_address = 8'h10;
        i_mem_write_data = 32'hDEADBEEF;
        i_mem_write_enable = 1'b1;
        @(negedge clk);
        check("fwd_same_cycle_old", o_mem_read_data, logical[4]);
        step();
        i_mem_write_enable = 1'b0;
        logical[4] = 32'hDEADBEEF;
        @(negedge clk);
        check("fwd_next_cycle", o_mem_read_data, 32'hDEADBEEF);
        repeat (4) cpu_read(8'h10, "fwd_hold");
        drain();
        do_reset();
        cpu_read(8'h10, "fwd_in_array_after_reset");
        // backpressure: from an empty queue only the sixth store has to wait, for one cycle
        for (int i = 0; i < 6; i++) cpu_store(8'(i * 4), $urandom, w[i]);
        for (int i = 0; i < 6; i++) check("bp_stall_wait", w[i], (i == 5) ? 1 : 0);
        drain();
        for (int i = 0; i < 6; i++) cpu_read(8'(i * 4), "bp_word");
        // same-address ordering
        cpu_store(8'h20, 32'h1, w0);
        cpu_store(8'h22, 32'h2, w0);
        cpu_read(8'h20, "same_addr_queued");
        cpu_read(8'h21, "same_addr_queued");
        drain();
        cpu_read(8'h20, "same_addr_drained");
        // host arbitration against a CPU store
        i_host_addr = 8'h30;
        i_host_wdata = 32'hA5A5A5A5;
        i_host_req_valid = 1'b1;
        i_host_req_write = 1'b1;
        d = $urandom;
        i_mem_write_address = 8'h34;
        i_mem_write_data = d;
        i_mem_write_enable = 1'b1;
        @(negedge clk);
        check("host_blocked_by_cpu", {31'b0, o_host_req_ready}, 0);
        step();
        i_mem_write_enable = 1'b0;
        logical[13] = d;
        @(negedge clk);
        check("host_ready_when_idle", {31'b0, o_host_req_ready}, 1);
        step();
        i_host_req_valid = 1'b0;
        logical[12] = 32'hA5A5A5A5;
        host_read(8'h30);
        step();
        cpu_read(8'h34, "cpu_store_beside_host");
        // clk_enable low freezes everything, including enqueue and read response
        clk_enable = 1'b0;
        i_mem_write_address = 8'h44;
        i_mem_write_data = ~logical[17];
        i_mem_write_enable = 1'b1;
        i_host_req_valid = 1'b1;
        i_host_req_write = 1'b0;
        i_host_addr = 8'h44;
        repeat (3) step();
        i_mem_write_enable = 1'b0;
        i_host_req_valid = 1'b0;
        clk_enable = 1'b1;
        cpu_read(8'h44, "freeze_no_store");
        // reset discards queued stores but keeps the array
        drain();
        host_write(8'h40, 32'h11);
        drain();
        cpu_store(8'h48, $urandom, w0);
        cpu_store(8'h4C, $urandom, w0);
        i_mem_write_address = 8'h40;
        i_mem_write_data = 32'h22;
        i_mem_write_enable = 1'b1;
        i_host_req_valid = 1'b1;
        i_host_req_write = 1'b0;
        i_host_addr = 8'h40;
        step();
        i_mem_write_enable = 1'b0;
        i_host_req_valid = 1'b0;
        do_reset();
        cpu_read(8'h40, "rst_queued_0x40");
        cpu_read(8'h48, "rst_queued_0x48");
        cpu_read(8'h4C, "rst_queued_0x4c");
        // randomized mix on a small address window to provoke collisions and stalls
        repeat (300) begin
            op = $urandom_range(0, 5);
            a = 8'(8'h80 + 4 * $urandom_range(0, 7) + $urandom_range(0, 3));
            d = $urandom;
            if (op <= 1) cpu_store(a, d, w0);
            else if (op == 2) host_write(a, d);
            else if (op == 3) host_read(a);
            else if (op == 4) cpu_read(a, "rand_cpu_read");
            else step();
        end
        drain();
        do_reset();
        for (int i = 0; i < 64; i++) cpu_read(8'(i * 4), "final_word");
        repeat (3) step();
        check("scoreboard_empty", exp_q.size(), 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
